sky_scene_sequencer: RTL

Frame-synchronous scene controller for the SkyKing VGA renderer. It watches the sync generator's vsync, derives a one-cycle frame tick and a frame counter, and runs the day-cycle state machine DAWN/DAY/DUSK/NIGHT. It moves the sun sprite position once per programmable number of frames. All scene outputs change only in the frame-tick cycle, inside vertical blanking, so the pixel datapath never sees a mid-frame change.

---
 rtl/sky_scene_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sky_scene_sequencer.sv
// Frame-synchronous day-cycle and sun-sprite controller for the SkyKing renderer.
// Scene state updates only on the vsync leading edge, so it changes inside vertical blanking.
module sky_scene_sequencer #(
    parameter int VS_ACTIVE_LOW   = 1,
    parameter int FRAMES_PER_STEP = 4,
    parameter int SUN_STEP        = 32,
    parameter int SUN_X_MIN       = 0,
    parameter int SUN_X_MAX       = 608,
    parameter int SUN_Y_LOW       = 400,
    parameter int SUN_Y_HIGH      = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       run,
    input  logic       step,
    output logic       frame_tick,
    output logic [9:0] frame_count,
    output logic [1:0] phase,
    output logic [9:0] sun_x,
    output logic [9:0] sun_y,
    output logic       sun_vis
);

    typedef enum logic [1:0] {
        DAWN  = 2'd0,
        DAY   = 2'd1,
        DUSK  = 2'd2,
        NIGHT = 2'd3
    } phase_t;

    localparam logic        VS_IDLE  = (VS_ACTIVE_LOW != 0);
    localparam logic [9:0]  X_MIN    = 10'(SUN_X_MIN);
    localparam logic [10:0] X_MAX    = 11'(SUN_X_MAX);
    localparam logic [10:0] X_STEP   = 11'(SUN_STEP);
    localparam logic [9:0]  Y_LOW    = 10'(SUN_Y_LOW);
    localparam logic [9:0]  Y_HIGH   = 10'(SUN_Y_HIGH);
    localparam logic [7:0]  DIV_LAST = 8'(FRAMES_PER_STEP - 1);

    phase_t      phase_q, phase_d;
    logic        vs_q;
    logic        tick_q;
    logic [9:0]  fc_q, fc_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        vis_q, vis_d;
    logic [7:0]  div_q, div_d;
    logic        pend_q, pend_d;
    logic        lead;
    logic        advance;
    logic [10:0] nx;

    assign lead = (vsync != VS_IDLE) && (vs_q == VS_IDLE);
    assign nx   = {1'b0, x_q} + X_STEP;

    always_comb begin
        phase_d = phase_q;
        fc_d    = fc_q;
        x_d     = x_q;
        div_d   = div_q;
        pend_d  = pend_q;
        advance = 1'b0;

        if (lead) begin
            fc_d = fc_q + 10'd1;
            if (run) begin
                if (div_q == DIV_LAST) begin
                    div_d   = 8'd0;
                    advance = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end else begin
                advance = pend_q || step;
            end
        end

        // A step landing on the tick is consumed by that tick.
        if (run || lead) begin
            pend_d = 1'b0;
        end else if (step) begin
            pend_d = 1'b1;
        end

        if (advance) begin
            if (nx <= X_MAX) begin
                x_d = nx[9:0];
            end else begin
                x_d = X_MIN;
                unique case (phase_q)
                    DAWN:    phase_d = DAY;
                    DAY:     phase_d = DUSK;
                    DUSK:    phase_d = NIGHT;
                    default: phase_d = DAWN;
                endcase
            end
        end

        y_d   = (phase_d == DAY) ? Y_HIGH : Y_LOW;
        vis_d = (phase_d != NIGHT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q    <= VS_IDLE;
            tick_q  <= 1'b0;
            fc_q    <= 10'd0;
            phase_q <= DAWN;
            x_q     <= X_MIN;
            y_q     <= Y_LOW;
            vis_q   <= 1'b1;
            div_q   <= 8'd0;
            pend_q  <= 1'b0;
        end else begin
            vs_q    <= vsync;
            tick_q  <= lead;
            fc_q    <= fc_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vis_q   <= vis_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
        end
    end

    assign frame_tick  = tick_q;
    assign frame_count = fc_q;
    assign phase       = phase_q;
    assign sun_x       = x_q;
    assign sun_y       = y_q;
    assign sun_vis     = vis_q;

endmodule
